// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: answers a host start pulse with a 40-bit frame on an open-drain bus.
// Optional macro DHT11_RESP_ERR_INJECT_EN adds err_inject to corrupt checksum bit 0.
`timescale 1ns/1ps
module dht11_responder #(
    parameter int unsigned TICKS_PER_US = 100,
    parameter int unsigned START_MIN_US = 18000,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
`ifdef DHT11_RESP_ERR_INJECT_EN
    input  logic       err_inject,
`endif
    input  logic       dq_in,
    output logic       dq_oe,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned PW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;

    typedef enum logic [2:0] {
        IDLE, HOST_LOW, RESP_WAIT, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dq_s;
    logic [PW-1:0]          pre;
    logic                   us_tick;
    logic [15:0]            us_cnt;
    logic [39:0]            shreg;
    logic [5:0]             bit_idx;
    logic [7:0]             chk;
    logic                   oe_d, busy_d, done_d;

    assign dq_s    = sync_q[SYNC_STAGES-1];
    assign us_tick = (pre == PW'(TICKS_PER_US - 1));

`ifdef DHT11_RESP_ERR_INJECT_EN
    assign chk = (hum_int + hum_dec + temp_int + temp_dec) ^ {7'b0, err_inject};
`else
    assign chk = hum_int + hum_dec + temp_int + temp_dec;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dq_oe      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            dq_oe      <= oe_d;
            busy       <= busy_d;
            frame_done <= done_d;
        end
    end

    // Each timed state exits on the last tick of its final microsecond, so D us = D*TICKS_PER_US cycles.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (!dq_s) state_next = HOST_LOW;
            HOST_LOW:  if (dq_s) state_next = (us_cnt >= 16'(START_MIN_US)) ? RESP_WAIT : IDLE;
            RESP_WAIT: if (us_tick && us_cnt == 16'd29) state_next = RESP_LOW;
            RESP_LOW:  if (us_tick && us_cnt == 16'd79) state_next = RESP_HIGH;
            RESP_HIGH: if (us_tick && us_cnt == 16'd79) state_next = BIT_LOW;
            BIT_LOW:   if (us_tick && us_cnt == 16'd49) state_next = BIT_HIGH;
            BIT_HIGH:  if (us_tick && us_cnt == (shreg[39] ? 16'd69 : 16'd25))
                           state_next = (bit_idx == 6'd39) ? END_LOW : BIT_LOW;
            END_LOW:   if (us_tick && us_cnt == 16'd49) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        oe_d   = (state_next == RESP_LOW) || (state_next == BIT_LOW) || (state_next == END_LOW);
        busy_d = (state_next != IDLE) && (state_next != HOST_LOW);
        done_d = (state == END_LOW) && (state_next == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '1;
            pre     <= '0;
            us_cnt  <= '0;
            shreg   <= '0;
            bit_idx <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], dq_in};
            if (state_next != state) begin
                pre    <= '0;
                us_cnt <= '0;
            end else begin
                pre <= us_tick ? '0 : pre + 1'b1;
                if (us_tick && us_cnt != '1) us_cnt <= us_cnt + 16'd1;
            end
            if (state == HOST_LOW && state_next == RESP_WAIT) begin
                shreg   <= {hum_int, hum_dec, temp_int, temp_dec, chk};
                bit_idx <= '0;
            end else if (state == BIT_HIGH && state_next != BIT_HIGH) begin
                shreg   <= {shreg[38:0], 1'b0};
                bit_idx <= bit_idx + 6'd1;
            end
        end
    end

endmodule
